reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Parametrised power-on and restart reset sequencer that generates NCH active-high reset outputs.
- Outputs are released strictly in order. Each stage is held for its own programmable cycle count after the previous stage releases.
- Sequencing is gated by a glitch-filtered lock input (TCXO/PLL good) and a synchronous restart request.
- Sits at chip level between the clock buffers and the PHY, ADC and datapath reset consumers. Tristate mapping (e.g. PHY nreset) stays in the chip wrapper.

Parameters:
- NCH, 3: number of reset outputs/stages (1..15).
- CW, 24: width of the stage delay counter.
- DLY, {24'd16, 24'd1000, 24'd16000000}: packed NCH*CW delay vector; stage k uses DLY[k*CW +: CW].
- LOCK_FILT, 16: consecutive high lock samples required before sequencing (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- lock  in  1  precondition (synchronous to clk); must be stable high to sequence.
- req  in  1  synchronous restart request, level-sensitive.
- rst_out  out  NCH  per-stage reset, active-high, registered.
- stage  out  4  index of the stage currently counting; 0 in IDLE; NCH in DONE.
- done  out  1  high when all stages are released.

Behaviour:
- Reset state: rst_out = all ones, done = 0, stage = 0, cnt = 0, lock_ok = 0, FSM = IDLE.
- Lock filter:
  - fcnt increments while lock = 1, saturating at LOCK_FILT.
  - Any lock = 0 sample clears fcnt and lock_ok at that edge.
  - lock_ok goes high at the edge where fcnt reaches LOCK_FILT, i.e. after LOCK_FILT consecutive high samples.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - rst_out all ones, done 0.
  - If lock_ok = 1 and req = 0, go to COUNT with stage = 0 and cnt = 0.
- COUNT, stage k, each edge:
  - If cnt >= DLY[k]: clear rst_out[k], set cnt = 0, then stage = k+1. If k = NCH-1, go to DONE instead, with done = 1 on the same edge.
  - Otherwise cnt = cnt+1.
  - Stage k therefore lasts DLY[k]+1 cycles. DLY[k] = 0 releases on the first COUNT edge.
  - The >= compare means cnt never wraps.
- DONE: rst_out all zeros, done 1; remain here until abort.
- Abort: in COUNT or DONE, if lock_ok = 0 or req = 1, the next edge goes to IDLE with rst_out all ones, done 0, stage 0, cnt 0.
  - Raw lock drop sampled at edge m clears lock_ok at m, so outputs reassert at m+1.
- Priority: reset > abort > release/count. An abort coinciding with a release keeps that stage in reset.
- req held high keeps the block in IDLE. Sequencing restarts from stage 0 on the first edge after req low, provided lock_ok = 1. The filter is not re-run.
- Outputs change only on clk edges. No combinational paths from inputs to outputs.
- Already-released stages are never reasserted individually; every abort reasserts all stages together.

Decomposition:
- Package reset_seq_pkg holds:
  - state encoding (IDLE = 0, COUNT = 1, DONE = 2);
  - stage width constant (4);
  - helper function dly_of(k) extracting the stage delay from the packed vector.
- Sub-module lock_filter (clk, reset, lock, lock_ok; parameter LOCK_FILT) implements the consecutive-high counter.
- The FSM, stage counter and delay counter stay in reset_sequencer.

Test Plan:
Parameters for all scenarios: NCH = 3, DLY = {5, 2, 3}, LOCK_FILT = 4.
- Nominal sequence: reset released, lock high from edge 1 -> lock_ok after edge 4; COUNT at edge 5; rst_out[0] falls at edge 9, rst_out[1] at 12, rst_out[2] at 18; done = 1 at 18; stage reads 0,1,2,3 accordingly.
- Lock glitch: lock high for 3 edges, low for 1, then high -> lock_ok delayed until 4 new consecutive highs; rst_out stays 3'b111 throughout the glitch.
- Mid-sequence lock loss: drop lock 1 cycle after rst_out[0] falls -> rst_out = 3'b111, stage = 0 one edge after lock_ok clears; the sequence restarts only after a fresh 4-sample filter.
- Restart request in DONE: pulse req for 1 cycle -> rst_out = 3'b111, done = 0 next edge; full sequence repeats with identical intervals (4, 3, 6 cycles).
- Boundary cases: DLY = {0, 0, 0} -> stages release on consecutive edges, done 3 edges after leaving IDLE. Abort and release on the same edge -> that stage stays asserted. Synchronous reset asserted mid-COUNT -> all outputs return to reset values at that edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the chip-level reset sequencer.
// Holds the FSM encoding, the stage-index width and the packed-delay extractor.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  localparam int STAGE_W   = 4;
  localparam int MAX_NCH   = 15;
  localparam int MAX_CW    = 32;
  localparam int DLY_VEC_W = MAX_NCH * MAX_CW;

  // Stage k's delay sits at vec[k*cw +: cw]; the caller truncates to its own cw.
  function automatic logic [MAX_CW-1:0] dly_of(input logic [DLY_VEC_W-1:0] vec,
                                                input int unsigned         cw,
                                                input int unsigned         k);
    return MAX_CW'(vec >> (k * cw));
  endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Glitch filter for the clock-good input: lock_ok rises only after
// LOCK_FILT consecutive high samples and drops on the first low sample.
module lock_filter #(
  parameter int LOCK_FILT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic lock,
  output logic lock_ok
);

  localparam int FW = $clog2(LOCK_FILT + 1);

  logic [FW-1:0] r_fcnt;
  logic          r_lock_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fcnt    <= '0;
      r_lock_ok <= 1'b0;
    end else if (!lock) begin
      r_fcnt    <= '0;
      r_lock_ok <= 1'b0;
    end else begin
      if (r_fcnt != FW'(LOCK_FILT)) r_fcnt <= r_fcnt + 1'b1;
      r_lock_ok <= (r_fcnt >= FW'(LOCK_FILT - 1));
    end
  end

  assign lock_ok = r_lock_ok;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered multi-stage reset release, gated by a filtered lock and a restart
// request; any abort reasserts every stage together.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                NCH       = 3,
  parameter int                CW        = 24,
  parameter logic [NCH*CW-1:0] DLY       = {24'd16, 24'd1000, 24'd16000000},
  parameter int                LOCK_FILT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lock,
  input  logic               req,
  output logic [NCH-1:0]     rst_out,
  output logic [STAGE_W-1:0] stage,
  output logic               done
);

  localparam logic [DLY_VEC_W-1:0] DLY_EXT = DLY_VEC_W'(DLY);

  seq_state_e         r_state, w_state_nxt;
  logic [STAGE_W-1:0] r_stage, w_stage_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NCH-1:0]     r_rst_out, w_rst_nxt;
  logic               r_done, w_done_nxt;
  logic               w_lock_ok;
  logic               w_abort;
  logic [CW-1:0]      w_cur_dly;
  logic [CW-1:0]      w_dly [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_dly
    assign w_dly[k] = CW'(dly_of(DLY_EXT, CW, k));
  end

  lock_filter #(
    .LOCK_FILT(LOCK_FILT)
  ) u_lock_filter (
    .clk    (clk),
    .reset  (reset),
    .lock   (lock),
    .lock_ok(w_lock_ok)
  );

  assign w_abort = !w_lock_ok || req;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_cur_dly   = '0;
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst_out;
    w_done_nxt  = r_done;

    for (int k = 0; k < NCH; k++) begin
      if (r_stage == STAGE_W'(k)) w_cur_dly = w_dly[k];
    end

    unique case (r_state)
      ST_IDLE: begin
        w_rst_nxt   = '1;
        w_done_nxt  = 1'b0;
        w_stage_nxt = '0;
        w_cnt_nxt   = '0;
        if (w_lock_ok && !req) w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_rst_nxt   = '1;
          w_done_nxt  = 1'b0;
          w_stage_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= w_cur_dly) begin
          // Stages release in order, so clearing the current bit is enough.
          w_rst_nxt = r_rst_out & ~(NCH'(1) << r_stage);
          w_cnt_nxt = '0;
          if (r_stage == STAGE_W'(NCH - 1)) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_stage_nxt = STAGE_W'(NCH);
          end else begin
            w_stage_nxt = r_stage + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_rst_nxt   = '1;
          w_done_nxt  = 1'b0;
          w_stage_nxt = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_rst_nxt  = '0;
          w_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_stage   <= '0;
      r_cnt     <= '0;
      r_rst_out <= '1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stage   <= w_stage_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rst_out <= w_rst_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign rst_out = r_rst_out;
  assign stage   = r_stage;
  assign done    = r_done;

endmodule
